// File: rtl/i2c_master.sv
// Byte-level I2C master: START, byte transmit with slave ACK, optional byte reads, STOP.
// SCL is push-pull; SDA is open-drain. Each SCL bit is four QTR-clk quarters.
module i2c_master #(
   parameter int unsigned QTR = 125
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        sda,
   output logic       sclk,
   input  logic [7:0] data,
   input  logic       en,
   output logic [2:0] st,
   output logic [7:0] out_i2c
);

   localparam int unsigned QW = (QTR > 2) ? $clog2(QTR) : 1;

   localparam logic [2:0] ST_STOP  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_SEND  = 3'd2;
   localparam logic [2:0] ST_ACK   = 3'd3;
   localparam logic [2:0] ST_NACK  = 3'd4;
   localparam logic [2:0] ST_READ  = 3'd5;

   typedef enum logic [2:0] {IDLE, START, LOAD, TX, TACK, RX, MACK, STOPG} state_t;

   state_t          state;
   logic [QW-1:0]   qcnt;
   logic [1:0]      q;
   logic [2:0]      bitn;
   logic [7:0]      txsh;
   logic [7:0]      rxsh;
   logic            sda_low;
   logic            rd_flag;
   logic            addr_ph;
   logic            ack_in;
   logic            mack;
   logic            qend;

   assign sda  = sda_low ? 1'b0 : 1'bz;
   assign qend = (qcnt == QW'(QTR - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sclk    <= 1'b1;
         sda_low <= 1'b0;
         st      <= ST_STOP;
         out_i2c <= 8'h00;
         qcnt    <= '0;
         q       <= 2'd0;
         bitn    <= 3'd0;
         txsh    <= 8'h00;
         rxsh    <= 8'h00;
         rd_flag <= 1'b0;
         addr_ph <= 1'b0;
         ack_in  <= 1'b0;
         mack    <= 1'b0;
      end else begin
         // quarter timebase; LOAD doubles as the first clk of bit 7's Q0
         if (state != IDLE && state != LOAD) begin
            qcnt <= qend ? '0 : qcnt + QW'(1);
            if (qend) q <= q + 2'd1;
         end

         case (state)
            IDLE: begin
               sclk    <= 1'b1;
               sda_low <= 1'b0;
               if (en) begin
                  state   <= START;
                  st      <= ST_START;
                  qcnt    <= '0;
                  q       <= 2'd0;
                  addr_ph <= 1'b1;
               end
            end
            START: if (qend) begin
               if (q == 2'd0) sda_low <= 1'b1;
               if (q == 2'd1) sclk <= 1'b0;
               if (q == 2'd2) state <= LOAD;
            end
            LOAD: begin
               txsh    <= data;
               sda_low <= ~data[7];
               st      <= ST_SEND;
               bitn    <= 3'd7;
               qcnt    <= QW'(1);
               q       <= 2'd0;
               state   <= TX;
               if (addr_ph) rd_flag <= data[0];
            end
            TX: if (qend) begin
               if (q == 2'd1) sclk <= 1'b1;
               if (q == 2'd3) begin
                  sclk <= 1'b0;
                  if (bitn == 3'd0) begin
                     state   <= TACK;
                     sda_low <= 1'b0;
                  end else begin
                     bitn    <= bitn - 3'd1;
                     txsh    <= {txsh[6:0], 1'b0};
                     sda_low <= ~txsh[6];
                  end
               end
            end
            TACK: if (qend) begin
               if (q == 2'd1) begin
                  sclk   <= 1'b1;
                  ack_in <= sda;
               end
               if (q == 2'd3) begin
                  sclk    <= 1'b0;
                  addr_ph <= 1'b0;
                  if (ack_in) begin
                     st      <= ST_NACK;
                     state   <= STOPG;
                     sda_low <= 1'b1;
                  end else begin
                     st <= ST_ACK;
                     if (rd_flag && addr_ph) begin
                        state <= RX;
                        bitn  <= 3'd7;
                     end else if (en) begin
                        state <= LOAD;
                     end else begin
                        state   <= STOPG;
                        sda_low <= 1'b1;
                     end
                  end
               end
            end
            RX: begin
               st <= ST_READ;
               if (qend) begin
                  if (q == 2'd1) begin
                     sclk <= 1'b1;
                     rxsh <= {rxsh[6:0], sda};
                  end
                  if (q == 2'd3) begin
                     sclk <= 1'b0;
                     if (bitn == 3'd0) begin
                        out_i2c <= rxsh;
                        state   <= MACK;
                        sda_low <= en;
                        mack    <= en;
                     end else begin
                        bitn <= bitn - 3'd1;
                     end
                  end
               end
            end
            MACK: if (qend) begin
               if (q == 2'd1) sclk <= 1'b1;
               if (q == 2'd3) begin
                  sclk <= 1'b0;
                  if (mack) begin
                     state   <= RX;
                     sda_low <= 1'b0;
                     bitn    <= 3'd7;
                  end else begin
                     state   <= STOPG;
                     sda_low <= 1'b1;
                  end
               end
            end
            STOPG: if (qend) begin
               if (q == 2'd0) sclk <= 1'b1;
               if (q == 2'd1) sda_low <= 1'b0;
               if (q == 2'd2) begin
                  st    <= ST_STOP;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: negedge-paced client, bus monitor with ACKing/reading slave,
// expected bytes queued at stimulus time and popped as the bus carries them.
module tb_i2c_master;

   localparam int unsigned QTR = 2;
   localparam logic [2:0] S_STOP  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_ACK   = 3'd3;
   localparam logic [2:0] S_NACK  = 3'd4;
   localparam logic [2:0] S_READ  = 3'd5;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] data;
   logic       sclk;
   logic [2:0] st;
   logic [7:0] out_i2c;
   logic       sl_low = 1'b0;
   wire        sda;

   pullup (sda);
   assign sda = (sl_low && !rst) ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_master #(.QTR(QTR)) dut (
      .clk(clk), .rst(rst), .sda(sda), .sclk(sclk),
      .data(data), .en(en), .st(st), .out_i2c(out_i2c)
   );

   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // bus monitor and slave model
   logic       pscl = 1'b1, psda = 1'b1;
   logic       in_txn = 1'b0, rd = 1'b0, sl_done = 1'b0, mack_seen = 1'b0;
   logic       slave_ack = 1'b1;
   logic [7:0] msh = 8'h00;
   logic [7:0] rd_byte = 8'h3C;
   int         bitn = 0, byte_idx = 0, rises = 0, stops = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_txn = 1'b0;
         sl_low = 1'b0;
      end else begin
         if (pscl && sclk && psda && !sda) begin
            in_txn = 1'b1; bitn = -1; byte_idx = 0;
            rd = 1'b0; sl_done = 1'b0; sl_low = 1'b0;
         end else if (pscl && sclk && !psda && sda) begin
            in_txn = 1'b0; stops++; sl_low = 1'b0;
         end
         if (!pscl && sclk) begin
            rises++;
            if (in_txn) begin
               if (bitn < 8) msh = {msh[6:0], sda};
               else if (rd && byte_idx > 0) begin
                  mack_seen = sda;
                  if (sda) sl_done = 1'b1;
               end
            end
         end
         if (pscl && !sclk && in_txn) begin
            bitn++;
            if (bitn == 9) begin bitn = 0; byte_idx++; end
            if (bitn == 8) begin
               if (!(rd && byte_idx > 0)) begin
                  int e;
                  e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
                  if (byte_idx == 0) rd = msh[0];
                  check("tx_byte", int'(msh), e);
                  sl_low = slave_ack;
               end else sl_low = 1'b0;
            end else if (rd && byte_idx > 0 && !sl_done) sl_low = ~rd_byte[3'(7 - bitn)];
            else sl_low = 1'b0;
         end
      end
      pscl = sclk;
      psda = sda;
   end

   task automatic wait_st(input logic [2:0] s, input string tag);
      int n = 0;
      while (st != s && n < 400) begin @(negedge clk); n++; end
      check(tag, int'(st), int'(s));
   endtask

   task automatic write_txn(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n, input string tag);
      logic [7:0] b [3];
      int r0, s0;
      b[0] = b0; b[1] = b1; b[2] = b2;
      r0 = rises; s0 = stops;
      data = b[0]; en = 1'b1; exp_q.push_back(b[0]);
      @(negedge clk);
      check({tag, "_start"}, int'(st), int'(S_START));
      for (int i = 0; i < n; i++) begin
         wait_st(S_SEND, {tag, "_send"});
         if (i == n - 1) en = 1'b0;
         wait_st(S_ACK, {tag, "_ack"});
         if (i < n - 1) begin
            data = b[i + 1];
            exp_q.push_back(b[i + 1]);
         end
      end
      wait_st(S_STOP, {tag, "_stop"});
      check({tag, "_scl_rises"}, rises - r0, 9 * n + 1);
      check({tag, "_stop_cond"}, stops - s0, 1);
   endtask

   initial begin
      int r0, s0;
      rst = 1'b1; en = 1'b0; data = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_sclk", int'(sclk), 1);
      check("rst_sda", int'(sda), 1);
      check("rst_st", int'(st), int'(S_STOP));
      check("rst_out", int'(out_i2c), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      write_txn(8'hA0, 8'h05, 8'h5A, 3, "wr3");

      // slave NACKs the address
      repeat (4) @(negedge clk);
      slave_ack = 1'b0;
      r0 = rises; s0 = stops;
      data = 8'hA0; en = 1'b1; exp_q.push_back(8'hA0);
      wait_st(S_SEND, "nack_send");
      wait_st(S_NACK, "nack_st");
      en = 1'b0;
      wait_st(S_STOP, "nack_stop");
      check("nack_scl_rises", rises - r0, 10);
      check("nack_stop_cond", stops - s0, 1);
      slave_ack = 1'b1;

      // single-byte read, master NACKs
      repeat (4) @(negedge clk);
      r0 = rises; s0 = stops;
      rd_byte = 8'h3C; rx_q.push_back(8'h3C);
      data = 8'hA1; en = 1'b1; exp_q.push_back(8'hA1);
      wait_st(S_SEND, "rd_send");
      en = 1'b0;
      wait_st(S_ACK, "rd_ack");
      wait_st(S_READ, "rd_read");
      wait_st(S_STOP, "rd_stop");
      check("rd_out", int'(out_i2c), int'(rx_q.pop_front()));
      check("rd_master_nack", int'(mack_seen), 1);
      check("rd_scl_rises", rises - r0, 19);
      check("rd_stop_cond", stops - s0, 1);

      // back-to-back: starts 1 clk after STOP, byte 2 replaces stale data
      data = 8'h05;
      write_txn(8'hA0, 8'h5A, 8'h00, 2, "wrA");
      write_txn(8'hA2, 8'h7E, 8'h00, 2, "b2b");

      // reset mid-byte
      repeat (4) @(negedge clk);
      data = 8'hA0; en = 1'b1; exp_q.push_back(8'hA0);
      wait_st(S_SEND, "mid_send");
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_sclk", int'(sclk), 1);
      check("mid_rst_sda", int'(sda), 1);
      check("mid_rst_st", int'(st), int'(S_STOP));
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      write_txn(8'hA0, 8'h11, 8'h00, 2, "post");
      check("exp_q_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
